draw_scheduler: RTL and testbench

- Frame-level scheduler that shares the single VGA pixel write port among NUM_REQ draw engines: ball, bricks and platform.
- On each frame tick it runs three phases in order:
  - erase pass: every requester redraws in black;
  - one-cycle position-update pulse;
  - colour pass: every requester redraws in its own colour.
- Sits between the delay counter / draw engines and the VGA adapter.
- Replaces the fixed-order draw FSM and the output mux.

---
 rtl/draw_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame scheduler sharing the VGA pixel port among draw engines: erase pass, inc pulse, colour pass.
// Optional macro DRAW_SCHED_CLIP_EN suppresses writes to off-screen pixels.
module draw_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int TIMEOUT  = 1023,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    done,
    input  logic [NUM_REQ*XW-1:0] px_x,
    input  logic [NUM_REQ*YW-1:0] px_y,
    input  logic [NUM_REQ*3-1:0]  px_colour,
    input  logic [NUM_REQ-1:0]    px_we,
    output logic [NUM_REQ-1:0]    go,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  iscolour,
    output logic                  inc_enable,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [2:0]            colour,
    output logic                  writeEn,
    output logic                  busy,
    output logic                  overrun,
    output logic [NUM_REQ-1:0]    timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PICK, GRANT, XFER, PASS_END, INC} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] mask;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gidx;
    logic [CW-1:0]      cnt;
    logic               early;

    logic               found;
    logic [IW-1:0]      pick;
    logic [XW-1:0]      sel_x;
    logic [YW-1:0]      sel_y;
    logic [2:0]         sel_c;
    logic               in_range;
    logic               finished;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin search: walk downward so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (mask[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_x = px_x[gidx*XW +: XW];
        sel_y = px_y[gidx*YW +: YW];
        sel_c = px_colour[gidx*3 +: 3];
`ifdef DRAW_SCHED_CLIP_EN
        in_range = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
`else
        in_range = 1'b1;
`endif
    end

    // A done coincident with go is latched so XFER's first cycle completes.
    assign finished = done[gidx] | early;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mask        <= '0;
            ptr         <= '0;
            gidx        <= '0;
            cnt         <= '0;
            early       <= 1'b0;
            go          <= '0;
            grant       <= '0;
            iscolour    <= 1'b0;
            inc_enable  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= 3'b000;
            writeEn     <= 1'b0;
        end else begin
            go         <= '0;
            inc_enable <= 1'b0;
            if (frame_tick && busy) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        mask     <= req;
                        iscolour <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PICK;
                    end
                end
                PICK: begin
                    if (found) begin
                        gidx  <= pick;
                        grant <= onehot(pick);
                        go    <= onehot(pick);
                        state <= GRANT;
                    end else begin
                        state <= PASS_END;
                    end
                end
                GRANT: begin
                    cnt   <= '0;
                    early <= done[gidx];
                    state <= XFER;
                end
                XFER: begin
                    if (finished) begin
                        mask[gidx] <= 1'b0;
                        grant      <= '0;
                        early      <= 1'b0;
                        state      <= PICK;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err[gidx] <= 1'b1;
                        mask[gidx]        <= 1'b0;
                        grant             <= '0;
                        state             <= PICK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PASS_END: begin
                    if (!iscolour) begin
                        inc_enable <= 1'b1;
                        state      <= INC;
                    end else begin
                        busy  <= 1'b0;
                        ptr   <= (ptr == IW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;
                        state <= IDLE;
                    end
                end
                INC: begin
                    mask     <= req;
                    iscolour <= 1'b1;
                    state    <= PICK;
                end
                default: state <= IDLE;
            endcase

            // Pixel path: one register stage behind the granted requester.
            writeEn <= (|grant) & px_we[gidx] & in_range;
            if (|grant) begin
                x      <= sel_x;
                y      <= sel_y;
                colour <= iscolour ? sel_c : 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: ordering, pixel path, timeout, overrun, reset abort.
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  done = 3'b000;
    logic [29:0] px_x = '0;
    logic [29:0] px_y = '0;
    logic [8:0]  px_colour = '0;
    logic [2:0]  px_we = 3'b000;
    logic [2:0]  go;
    logic [2:0]  grant;
    logic        iscolour;
    logic        inc_enable;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic        overrun;
    logic [2:0]  timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] resp_en = 3'b111;
    logic [2:0] imm     = 3'b000;
    int dcnt[3] = '{0, 0, 0};
    int gcnt[3] = '{0, 0, 0};
    int q[$];

    draw_scheduler #(.NUM_REQ(3), .XW(10), .YW(10), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .req(req), .done(done),
        .px_x(px_x), .px_y(px_y), .px_colour(px_colour), .px_we(px_we),
        .go(go), .grant(grant), .iscolour(iscolour), .inc_enable(inc_enable),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Requester responder and event log (go index, 9 = inc_enable pulse)
    initial begin
        logic dv;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                dv = 1'b0;
                if (dcnt[i] != 0) begin
                    dcnt[i]--;
                    if (dcnt[i] == 0) dv = 1'b1;
                end
                if (go[i]) begin
                    if (imm[i]) dv = 1'b1;
                    else if (resp_en[i]) dcnt[i] = 4;
                end
                done[i] = dv;
                if (grant[i]) gcnt[i]++;
                if (go[i]) q.push_back(i);
            end
            if (inc_enable) q.push_back(9);
        end
    end

    function automatic int seq_code();
        int c = 0;
        foreach (q[i]) c = c * 16 + q[i] + 1;
        return c;
    endfunction

    task automatic run_frame(output bit ok);
        q.delete();
        gcnt = '{0, 0, 0};
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (int n = 0; n < 400 && busy; n++) @(negedge clk);
        ok = !busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({go, grant, iscolour, inc_enable, writeEn, busy, overrun, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {go, grant, iscolour, inc_enable, writeEn, busy, overrun, timeout_err});
        end
        n_checks++;
        if ({x, y, colour} !== '0) begin
            n_fail++;
            $display("FAIL reset_pix got x=%0d y=%0d c=%b want 0", x, y, colour);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit ok;
        req = 3'b111;
        resp_en = 3'b111;
        run_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr1_done busy stuck"); end
        n_checks++;
        if (seq_code() !== 32'h123A123) begin
            n_fail++;
            $display("FAIL rr1_order got=%h want=123a123", seq_code());
        end
        run_frame(ok);
        n_checks++;
        if (seq_code() !== 32'h231A231) begin
            n_fail++;
            $display("FAIL rr2_order got=%h want=231a231", seq_code());
        end
    endtask

    task automatic test_pixel_path;
        int n;
        req = 3'b001;
        px_x[9:0] = 10'd12;
        px_y[9:0] = 10'd30;
        px_colour[2:0] = 3'b101;
        px_we = 3'b001;
        q.delete();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (grant[0] && !iscolour) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (n >= 200 || {x, y, colour, writeEn} !== {10'd12, 10'd30, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL erase_pixel got x=%0d y=%0d c=%b we=%b want 12 30 000 1", x, y, colour, writeEn);
        end
        for (n = 0; n < 200; n++) begin
            if (grant[0] && iscolour) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (n >= 200 || {x, y, colour, writeEn} !== {10'd12, 10'd30, 3'b101, 1'b1}) begin
            n_fail++;
            $display("FAIL colour_pixel got x=%0d y=%0d c=%b we=%b want 12 30 101 1", x, y, colour, writeEn);
        end
        for (n = 0; n < 200 && busy; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({writeEn, x, colour} !== {1'b0, 10'd12, 3'b101}) begin
            n_fail++;
            $display("FAIL idle_hold got we=%b x=%0d c=%b want 0 12 101", writeEn, x, colour);
        end
        px_we = 3'b000;
    endtask

    task automatic test_single;
        int n, dcyc;
        req = 3'b010;
        q.delete();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        dcyc = -1;
        for (n = 0; n < 400 && busy; n++) begin
            if (done[1] && iscolour) dcyc = n;
            @(negedge clk);
        end
        n_checks++;
        if (seq_code() !== 32'h2A2) begin
            n_fail++;
            $display("FAIL single_order got=%h want=2a2", seq_code());
        end
        n_checks++;
        if (dcyc < 0 || n - dcyc < 1 || n - dcyc > 3) begin
            n_fail++;
            $display("FAIL single_busy_fall got=%0d cycles after done want 1..3", n - dcyc);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        req = 3'b111;
        resp_en = 3'b011;
        run_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL to_frame busy stuck"); end
        n_checks++;
        if (timeout_err !== 3'b100) begin
            n_fail++;
            $display("FAIL to_flag got=%b want=100", timeout_err);
        end
        n_checks++;
        if (gcnt[2] !== 34) begin
            n_fail++;
            $display("FAIL to_grant_len got=%0d want=34", gcnt[2]);
        end
        n_checks++;
        if (gcnt[1] !== 10) begin
            n_fail++;
            $display("FAIL to_other_len got=%0d want=10", gcnt[1]);
        end
        resp_en = 3'b111;
    endtask

    task automatic test_empty;
        bit ok;
        req = 3'b000;
        run_frame(ok);
        n_checks++;
        if (!ok || seq_code() !== 32'hA) begin
            n_fail++;
            $display("FAIL empty_frame got=%h ok=%0d want=a", seq_code(), ok);
        end
    endtask

    task automatic test_done_with_go;
        bit ok;
        req = 3'b001;
        imm = 3'b001;
        run_frame(ok);
        n_checks++;
        if (!ok || seq_code() !== 32'h1A1) begin
            n_fail++;
            $display("FAIL imm_order got=%h want=1a1", seq_code());
        end
        n_checks++;
        if (gcnt[0] !== 4) begin
            n_fail++;
            $display("FAIL imm_grant_len got=%0d want=4", gcnt[0]);
        end
        imm = 3'b000;
    endtask

    task automatic test_overrun;
        req = 3'b001;
        q.delete();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre got=%b want=0", overrun);
        end
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (int n = 0; n < 400 && busy; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag got=%b want=1", overrun);
        end
        n_checks++;
        if (seq_code() !== 32'h1A1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_nopass got=%h busy=%b want=1a1 0", seq_code(), busy);
        end
        n_checks++;
        if (timeout_err !== 3'b100) begin
            n_fail++;
            $display("FAIL sticky_to got=%b want=100", timeout_err);
        end
    endtask

`ifdef DRAW_SCHED_CLIP_EN
    task automatic test_clip;
        int n;
        req = 3'b001;
        px_x[9:0] = 10'd640;
        px_we = 3'b001;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (n = 0; n < 200 && !grant[0]; n++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (writeEn !== 1'b0 || x !== 10'd640) begin
            n_fail++;
            $display("FAIL clip_640 got we=%b x=%0d want 0 640", writeEn, x);
        end
        px_x[9:0] = 10'd639;
        @(negedge clk);
        n_checks++;
        if (writeEn !== 1'b1) begin
            n_fail++;
            $display("FAIL clip_639 got we=%b want 1", writeEn);
        end
        px_we = 3'b000;
        for (n = 0; n < 400 && busy; n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid;
        int n;
        req = 3'b111;
        px_x = {10'd7, 10'd8, 10'd9};
        px_y = {10'd1, 10'd2, 10'd3};
        px_colour = 9'b111_111_111;
        px_we = 3'b111;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (grant !== 3'b000 && go === 3'b000) break;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({go, grant, iscolour, inc_enable, writeEn, busy, overrun, timeout_err} !== '0
            || {x, y, colour} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got ctrl=%b x=%0d y=%0d c=%b want all 0",
                     {go, grant, iscolour, inc_enable, writeEn, busy, overrun, timeout_err}, x, y, colour);
        end
        reset = 1'b0;
        q.delete();
        repeat (10) @(negedge clk);
        n_checks++;
        if (q.size() !== 0 || writeEn !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got events=%0d we=%b busy=%b want 0 0 0", q.size(), writeEn, busy);
        end
        px_we = 3'b000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pixel_path();
        test_single();
        test_timeout();
        test_empty();
        test_done_with_go();
        test_overrun();
`ifdef DRAW_SCHED_CLIP_EN
        test_clip();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
